// File: rtl/velocity_cell_pingpong.sv
// Double-buffered per-cell velocity store: reads come from the active bank, writes append to the shadow bank.
// Optional macro VELOCITY_RD_OUTREG_EN adds a second read output register (read latency 2 instead of 1).
module velocity_cell_pingpong #(
  parameter int COMP_WIDTH = 32,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [3*COMP_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]    rd_count,
  input  logic                    wr_en,
  input  logic [3*COMP_WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic                    wr_overflow,
  input  logic                    swap_req,
  output logic                    swap_done,
  output logic                    active_bank
);
  localparam int DATA_WIDTH = 3*COMP_WIDTH;
`ifdef VELOCITY_RD_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT-1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWAP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             drain_q, drain_d;
  logic                   run, do_swap;
  logic                   active_q;
  logic [CNT_WIDTH-1:0]   rd_count_q, wr_count_q;
  logic                   wr_ovf_q, swap_done_q;
  logic                   rd1_valid_q;
  logic [DATA_WIDTH-1:0]  rd1_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [2][DEPTH];

  logic rd_acc, wr_acc, wr_room, rd_hit;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    run     = 1'b0;
    do_swap = 1'b0;
    case (state_q)
      S_RUN: begin
        run = 1'b1;
        if (swap_req) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = S_SWAP;
          do_swap = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      S_SWAP:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign rd_acc  = rd_en & run;
  assign wr_acc  = wr_en & run;
  assign wr_room = wr_count_q < CNT_WIDTH'(DEPTH);
  assign rd_hit  = CNT_WIDTH'(rd_addr) < rd_count_q;

  // Bank exchange is committed on the edge entering SWAP so the new count,
  // bank index and swap_done all appear together in the SWAP cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_q     <= 2'd0;
      active_q    <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      wr_ovf_q    <= 1'b0;
      swap_done_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      swap_done_q <= do_swap;
      if (do_swap) begin
        active_q   <= ~active_q;
        rd_count_q <= wr_count_q;
        wr_count_q <= '0;
        wr_ovf_q   <= 1'b0;
      end else if (wr_acc) begin
        if (wr_room) wr_count_q <= wr_count_q + CNT_WIDTH'(1);
        else         wr_ovf_q   <= 1'b1;
      end
      rd1_valid_q <= rd_acc;
      rd1_data_q  <= (rd_acc && rd_hit) ? mem_q[active_q][rd_addr] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc && wr_room) mem_q[~active_q][wr_count_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

`ifdef VELOCITY_RD_OUTREG_EN
  logic                  rd2_valid_q;
  logic [DATA_WIDTH-1:0] rd2_data_q;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd2_valid_q <= 1'b0;
      rd2_data_q  <= '0;
    end else begin
      rd2_valid_q <= rd1_valid_q;
      rd2_data_q  <= rd1_data_q;
    end
  end
  assign rd_valid = rd2_valid_q;
  assign rd_data  = rd2_data_q;
`else
  assign rd_valid = rd1_valid_q;
  assign rd_data  = rd1_data_q;
`endif

  assign rd_ready    = run;
  assign wr_ready    = run;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign wr_overflow = wr_ovf_q;
  assign swap_done   = swap_done_q;
  assign active_bank = active_q;
endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Randomized + directed bench for velocity_cell_pingpong against a bank/queue-level model.
module tb_velocity_cell_pingpong;
`ifdef VELOCITY_RD_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int DEPTH = 220;

  logic        clock = 1'b0, rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [95:0] wr_data = '0;
  logic        rd_ready, rd_valid, wr_ready, wr_overflow, swap_done, active_bank;
  logic [95:0] rd_data;
  logic [8:0]  rd_count, wr_count;

  velocity_cell_pingpong dut (
    .clock(clock), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_count(rd_count),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .wr_count(wr_count),
    .wr_overflow(wr_overflow),
    .swap_req(swap_req), .swap_done(swap_done), .active_bank(active_bank)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  // Model: two banks as plain arrays, counts, and a busy countdown covering drain+swap.
  logic [95:0] bank [2][256];
  int          act, rdcnt, wrcnt, busy;
  bit          ovf;
  bit          pv [2];
  logic [95:0] pd [2];

  task automatic model_reset();
    act = 0; rdcnt = 0; wrcnt = 0; busy = 0; ovf = 1'b0;
    for (int j = 0; j < 2; j++) begin pv[j] = 1'b0; pd[j] = '0; end
  endtask

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(posedge clock) begin
    bit rdy, nv;
    logic [95:0] nd;
    if (rst_n) begin
      rdy = (busy == 0);
      nv  = rdy && rd_en;
      nd  = (nv && rd_addr < rdcnt) ? bank[act][rd_addr] : 96'h0;
      if (rdy && wr_en) begin
        if (wrcnt < DEPTH) begin bank[1-act][wrcnt] = wr_data; wrcnt++; end
        else ovf = 1'b1;
      end
      if (busy > 0) begin
        busy--;
        if (busy == 1) begin act = 1 - act; rdcnt = wrcnt; wrcnt = 0; ovf = 1'b0; end
      end
      if (rdy && swap_req) busy = RD_LAT + 1;
      for (int j = RD_LAT-1; j > 0; j--) begin pv[j] = pv[j-1]; pd[j] = pd[j-1]; end
      pv[0] = nv; pd[0] = nd;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("rd_valid", rd_valid, pv[RD_LAT-1]);
      if (pv[RD_LAT-1]) chk("rd_data", rd_data, pd[RD_LAT-1]);
      chk("rd_count", rd_count, rdcnt);
      chk("wr_count", wr_count, wrcnt);
      chk("wr_overflow", wr_overflow, ovf);
      chk("active_bank", active_bank, act);
      chk("swap_done", swap_done, busy == 1);
      chk("rd_ready", rd_ready, busy == 0);
      chk("wr_ready", wr_ready, busy == 0);
    end
  end

  task automatic step(input bit re, input logic [7:0] ra, input bit we,
                      input logic [95:0] wd, input bit sw);
    rd_en = re; rd_addr = ra; wr_en = we; wr_data = wd; swap_req = sw;
    @(posedge clock); #3;
    rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0, 96'h0, 1'b0);
  endtask

  task automatic read_lit(input string nm, input logic [7:0] a, input logic [95:0] e);
    step(1'b1, a, 1'b0, 96'h0, 1'b0);
    idle(RD_LAT-1);
    chk({nm, "_v"}, rd_valid, 1'b1);
    chk(nm, rd_data, e);
  endtask

  initial begin
    int n;
    logic [95:0] w;
    model_reset();
    // 1: reset values
    #12;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 96'h0);
    chk("rst_counts", {rd_count, wr_count}, 18'h0);
    chk("rst_flags", {wr_overflow, swap_done, active_bank}, 3'b000);
    @(posedge clock); #3;
    rst_n = 1'b1; chk_on = 1'b1;
    read_lit("empty_rd", 8'd0, 96'h0);

    // 2: fill five words and swap
    for (int i = 1; i <= 5; i++) step(1'b0, 8'd0, 1'b1, {3{32'(i)}}, 1'b0);
    step(1'b0, 8'd0, 1'b0, 96'h0, 1'b1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (swap_done) break;
      n++; @(posedge clock); #3;
    end
    chk("swap_lat", n + 1, RD_LAT + 1);
    chk("swap_rd_count", rd_count, 9'd5);
    chk("swap_active", active_bank, 1'b1);
    idle(1);
    for (int a = 0; a <= 5; a++) step(1'b1, 8'(a), 1'b0, 96'h0, 1'b0);
    idle(RD_LAT);
    read_lit("rd_addr4", 8'd4, 96'h00000005_00000005_00000005);
    read_lit("rd_addr5", 8'd5, 96'h0);

    // 3: overflow
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 8'd0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    chk("ovf_wr_count", wr_count, 9'd220);
    chk("ovf_flag", wr_overflow, 1'b1);
    step(1'b0, 8'd0, 1'b0, 96'h0, 1'b1);
    idle(RD_LAT);
    chk("ovf_cleared", wr_overflow, 1'b0);
    chk("ovf_rd_count", rd_count, 9'd220);
    idle(1);
    step(1'b1, 8'd219, 1'b0, 96'h0, 1'b0);
    step(1'b1, 8'd220, 1'b0, 96'h0, 1'b0);
    idle(RD_LAT);

    // 4: simultaneous write/read with swap, activity ignored during drain/swap
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    step(1'b1, 8'd2, 1'b1, 96'hAAAA, 1'b1);
    for (int k = 0; k < RD_LAT; k++) step(1'b1, 8'd0, 1'b1, 96'hBBBB, 1'b0);
    chk("sim_swap_done", swap_done, 1'b1);
    chk("sim_rd_count", rd_count, 9'd4);
    step(1'b1, 8'd0, 1'b1, 96'hCCCC, 1'b0);
    idle(RD_LAT);
    read_lit("sim_rd3", 8'd3, 96'hAAAA);

    // 5: reset during drain
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    step(1'b1, 8'd1, 1'b0, 96'h0, 1'b1);
    rst_n = 1'b0; model_reset();
    #1;
    chk("mid_rst_active", active_bank, 1'b0);
    chk("mid_rst_counts", {rd_count, wr_count}, 18'h0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_done", swap_done, 1'b0);
    @(posedge clock); @(posedge clock); #3;
    rst_n = 1'b1;
    idle(RD_LAT + 3);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      w = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, w, $urandom_range(0, 49) == 0);
    end
    idle(RD_LAT + 2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
